systolic_feed_ctrl: RTL
=======================

# systolic_feed_ctrl

Sequencer for the ROWS×COLS systolic array core. On a start pulse it reads K operand vectors (one A row-vector and one B column-vector per step) from the operand buffers. It applies the diagonal skew the array needs: A lane r is delayed r cycles, B lane c is delayed c cycles. It drives the array's A/B data and valid inputs, then waits for every PE to report a result before pulsing done. It sits between the operand SRAM/buffer interface and the array core, and runs one matrix tile per start.

## Interface
- DBITS, 8, operand width per lane
- ROWS, 2, array rows (A lanes)
- COLS, 2, array columns (B lanes)
- KBITS, 8, width of inner-dimension length and read address
- i_CLK  in  1  clock, all logic rising-edge
- i_RST  in  1  reset, synchronous, active-high
- i_START  in  1  start request; sampled only in IDLE
- i_K  in  KBITS  inner-dimension length; latched when start accepted
- o_BUSY  out  1  high in FEED, DRAIN, DONE
- o_DONE  out  1  one-cycle pulse at tile completion
- o_RD_EN  out  1  operand buffer read strobe
- o_RD_ADDR  out  KBITS  operand index k, shared by A and B buffers
- i_A_RDATA  in  ROWS*DBITS  A vector for k; valid 1 cycle after o_RD_EN
- i_B_RDATA  in  COLS*DBITS  B vector for k; valid 1 cycle after o_RD_EN
- o_A  out  ROWS*DBITS  skewed A lanes to array, lane r at [r*DBITS +: DBITS]
- o_A_VALID  out  ROWS  per-lane A valid
- o_B  out  COLS*DBITS  skewed B lanes to array
- o_B_VALID  out  COLS  per-lane B valid
- i_OUT_VALID  in  ROWS*COLS  array per-PE result valid

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: if i_START=1, latch i_K, clear the sticky result mask and the read counter. Go to DONE if K=0, otherwise to FEED. i_START in any other state is ignored, with no queuing.
- FEED: o_RD_EN=1 and o_RD_ADDR=k for k=0..K-1, one per cycle. After the cycle issuing k=K-1, go to DRAIN.
- Capture stage: registered valid rd_v = o_RD_EN delayed 1 cycle. When rd_v=1, i_A_RDATA/i_B_RDATA enter the lane-0 stage of every skew line.
- Skew lines: A lane r is a register chain of depth 1+r; B lane c has depth 1+c. Data and valid move together. Lane output data is forced to 0 whenever its valid is 0.
- Sticky mask: bit p is set on any cycle with i_OUT_VALID[p]=1, in any non-IDLE state, including the cycle the mask completes.
- DRAIN: go to DONE when two conditions hold together: all skew-line valids plus rd_v are 0, and the sticky mask is all ones, with the current i_OUT_VALID included.
- DONE: o_DONE=1 for exactly one cycle, then go to IDLE.
- No timeout. If the array never reports, the block stays in DRAIN until reset.
- i_RST at any time, including mid-FEED or mid-DRAIN, has the following effect next cycle:
  - state returns to IDLE;
  - all skew registers, rd_v, the counter and the mask are cleared;
  - all outputs go to 0.
- Reset value of every output is 0.
- Width rules: the k counter is KBITS wide and counts only up to K-1 ≤ 2^KBITS-2, so it never wraps. The mask is ROWS*COLS bits.

## Timing
- Start accepted at cycle t, in IDLE with i_START=1. The following holds when K>0:
  - o_BUSY=1 from t+1.
  - o_RD_EN=1 on t+1..t+K, with addr 0..K-1.
  - i_*_RDATA is consumed on t+2..t+K+1.
  - A lane r and B lane c are valid on t+3+r..t+K+2+r and t+3+c..t+K+2+c respectively, with element k on cycle t+3+k+lane.
  - The last lane valid is at t+K+2+max(ROWS,COLS)-1.
  - The DONE state is entered on the cycle after both DRAIN conditions are met. o_DONE and the last o_BUSY fall in the same cycle; o_BUSY=0 the next cycle.
- K=0: o_DONE=1 at t+1. No reads and no valids.
- Earliest restart: i_START is sampled on the cycle after o_DONE.

## Test plan
- ROWS=COLS=2, K=4, A rows {1,2},{3,4},{5,6},{7,8}, B likewise. Required response:
  - o_RD_EN at t+1..t+4, addr 0..3.
  - A lane0 valid t+3..t+6 with 1,3,5,7; lane1 valid t+4..t+7 with 2,4,6,8.
  - B lanes skewed identically.
  - Drive i_OUT_VALID=4'b1111 at t+10, giving o_DONE=1 at t+11.
- K=0 start, giving o_DONE at t+1. o_RD_EN, o_A_VALID and o_B_VALID stay 0 throughout.
- i_START held high during FEED and DRAIN: no second tile. After o_DONE a new start begins at addr 0, and the latched K is unchanged by i_K changes mid-tile.
- Drive i_OUT_VALID bits one at a time (bit0 at t+5, bit3 at t+20), others later. Required response: o_DONE only at the cycle after the last bit sets the mask, and never before the skew lines are empty.
- i_RST asserted at t+3 of a K=8 tile: next cycle all outputs are 0 and state is IDLE. A subsequent start with K=2 produces exactly 2 reads and clean skewed valids.
- K=255 (KBITS=8): 255 consecutive reads with addr 0..254 and no wrap. o_DONE pulses once.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Sequencer feeding one ROWS x COLS systolic array tile per start request.
// Reads K operand vectors (A row-vector + B column-vector per step) from the
// operand buffers, skews them diagonally (A lane r delayed r cycles, B lane c
// delayed c cycles), drives the array inputs, then waits for every PE to
// report a result before pulsing done.
//
// Ports:
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_START, i_K          start request (sampled in IDLE), inner-dimension length
//   o_BUSY, o_DONE        busy during FEED/DRAIN/DONE, one-cycle completion pulse
//   o_RD_EN, o_RD_ADDR    operand buffer read strobe and index k
//   i_A_RDATA, i_B_RDATA  operand vectors, valid one cycle after o_RD_EN
//   o_A, o_A_VALID        skewed A lanes to the array
//   o_B, o_B_VALID        skewed B lanes to the array
//   i_OUT_VALID           per-PE result valid from the array
module systolic_feed_ctrl #(
    parameter int DBITS = 8,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int KBITS = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_START,
    input  logic [KBITS-1:0]      i_K,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_RD_EN,
    output logic [KBITS-1:0]      o_RD_ADDR,
    input  logic [ROWS*DBITS-1:0] i_A_RDATA,
    input  logic [COLS*DBITS-1:0] i_B_RDATA,
    output logic [ROWS*DBITS-1:0] o_A,
    output logic [ROWS-1:0]       o_A_VALID,
    output logic [COLS*DBITS-1:0] o_B,
    output logic [COLS-1:0]       o_B_VALID,
    input  logic [ROWS*COLS-1:0]  i_OUT_VALID
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                 state;
    logic [KBITS-1:0]       k_lat;
    logic [KBITS-1:0]       cnt;
    logic                   rd_v;
    logic [ROWS*COLS-1:0]   mask;
    logic [ROWS*COLS-1:0]   mask_nxt;
    logic [ROWS-1:0]        a_busy;
    logic [COLS-1:0]        b_busy;
    logic                   pipe_busy;

    // Current-cycle result valids count toward completion immediately.
    assign mask_nxt  = mask | i_OUT_VALID;
    // Any valid still in flight anywhere in the capture stage or skew lines.
    assign pipe_busy = rd_v | (|a_busy) | (|b_busy);
    assign o_RD_ADDR = cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state   <= IDLE;
            k_lat   <= '0;
            cnt     <= '0;
            rd_v    <= 1'b0;
            mask    <= '0;
            o_RD_EN <= 1'b0;
            o_BUSY  <= 1'b0;
            o_DONE  <= 1'b0;
        end else begin
            rd_v <= o_RD_EN;
            if (state != IDLE) begin
                mask <= mask_nxt;
            end
            case (state)
                IDLE: begin
                    if (i_START) begin
                        k_lat  <= i_K;
                        cnt    <= '0;
                        mask   <= '0;
                        o_BUSY <= 1'b1;
                        if (i_K == '0) begin
                            state  <= DONE;
                            o_DONE <= 1'b1;
                        end else begin
                            state   <= FEED;
                            o_RD_EN <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (cnt == k_lat - KBITS'(1)) begin
                        o_RD_EN <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        cnt <= cnt + KBITS'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_busy && (&mask_nxt)) begin
                        state  <= DONE;
                        o_DONE <= 1'b1;
                    end
                end
                DONE: begin
                    o_DONE <= 1'b0;
                    o_BUSY <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skew lines: lane n is a chain of n+1 stages. Data is zeroed on entry
    // when not valid, so every stage output is already forced to 0 when idle.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        logic [DBITS-1:0] d [0:r];
        logic [r:0]       v;

        always_ff @(posedge i_CLK) begin
            if (i_RST) begin
                v <= '0;
                for (int unsigned s = 0; s <= r; s++) d[s] <= '0;
            end else begin
                v[0] <= rd_v;
                d[0] <= rd_v ? i_A_RDATA[r*DBITS +: DBITS] : '0;
                for (int unsigned s = 1; s <= r; s++) begin
                    v[s] <= v[s-1];
                    d[s] <= d[s-1];
                end
            end
        end

        assign o_A[r*DBITS +: DBITS] = d[r];
        assign o_A_VALID[r]          = v[r];
        assign a_busy[r]             = |v;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        logic [DBITS-1:0] d [0:c];
        logic [c:0]       v;

        always_ff @(posedge i_CLK) begin
            if (i_RST) begin
                v <= '0;
                for (int unsigned s = 0; s <= c; s++) d[s] <= '0;
            end else begin
                v[0] <= rd_v;
                d[0] <= rd_v ? i_B_RDATA[c*DBITS +: DBITS] : '0;
                for (int unsigned s = 1; s <= c; s++) begin
                    v[s] <= v[s-1];
                    d[s] <= d[s-1];
                end
            end
        end

        assign o_B[c*DBITS +: DBITS] = d[c];
        assign o_B_VALID[c]          = v[c];
        assign b_busy[c]             = |v;
    end

endmodule
